sgi_initiator: RTL and testbench

Bus initiator that turns local software-generated-interrupt (SGI) requests into MemSplit32 write transactions targeting the MSI register (offset 0xC) of a remote tile's SFR block. It sits in each tile between the interrupt/IPI logic and the tile's outbound MemSplit32 port. Requests are buffered in a small FIFO and issued one at a time with a req/ack handshake. An optional ack-timeout watchdog keeps a dead target from stalling the queue.

---
 rtl/sgi_pkg.sv | 32 +++
 rtl/memsplit32_if.sv | 18 +
 rtl/sgi_fifo.sv | 72 +++++++
 rtl/sgi_initiator.sv | 178 +++++++++++++++++
 tb/tb_sgi_initiator.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgi_pkg.sv
// Shared definitions for the SGI initiator and the tile SFR slave:
// SFR register offsets, the queued request entry and the initiator FSM states.
package sgi_pkg;

   // SFR register offsets inside one tile's SFR window
   localparam logic [7:0] SGI_SFR_IDCODE  = 8'h0;
   localparam logic [7:0] SGI_SFR_CTRL    = 8'h4;
   localparam logic [7:0] SGI_SFR_CORENUM = 8'h8;
   localparam logic [7:0] SGI_SFR_MSI     = 8'hC;

   // Default field widths of a queued SGI request
   localparam int unsigned SGI_TGT_W  = 4;
   localparam int unsigned SGI_CODE_W = 4;

   typedef struct packed {
      logic [SGI_TGT_W-1:0]  tgt;
      logic [SGI_CODE_W-1:0] code;
   } sgi_entry_t;

   typedef enum logic [0:0] {
      SGI_IDLE = 1'b0,
      SGI_REQ  = 1'b1
   } sgi_state_e;

   // MSI register address of a target tile; 32-bit arithmetic wraps on overflow
   function automatic logic [31:0] sgi_msi_addr(input logic [31:0] base,
                                                input logic [31:0] tgt,
                                                input int unsigned stride_pow);
      return base + (tgt << stride_pow) + {24'h0, SGI_SFR_MSI};
   endfunction

endpackage

// File: rtl/memsplit32_if.sv
// MemSplit32 bus: split request/response memory port, 32-bit address and data.
// Handshake: the master raises req with stable we/addr/be/wdata and holds them
// until it samples ack=1 at a rising clock edge; that edge completes the transfer.
interface MemSplit32;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [1:0]  resp;
   logic [31:0] rdata;

   modport Master (output req, we, addr, be, wdata,
                   input  ack, resp, rdata);
   modport Slave  (input  req, we, addr, be, wdata,
                   output ack, resp, rdata);
endinterface

// File: rtl/sgi_fifo.sv
// Synchronous FIFO with asynchronous reset and show-ahead head output.
// A push while full and a pop while empty are ignored; full is taken from the
// registered count, so a push against a full FIFO is dropped even if a pop
// happens on the same edge.
module sgi_fifo #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH_POW = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_POW;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_POW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_POW:0]   count_q, count_d;
   logic                 do_push;
   logic                 do_pop;

   assign full_o  = (count_q == (DEPTH_POW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents need no reset since the count qualifies them
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/sgi_initiator.sv
// SGI initiator: queues local SGI requests and issues each one as a MemSplit32
// write of the zero-extended code to the MSI register of the target tile.
// Optional ack-timeout watchdog: define SGI_INITIATOR_TIMEOUT_EN.
module sgi_initiator
   import sgi_pkg::*;
#(
   parameter int unsigned IRQ_NUM_POW     = 4,
   parameter int unsigned TGT_NUM_POW     = 4,
   parameter int unsigned FIFO_DEPTH_POW  = 2,
   parameter logic [31:0] SFR_BASE        = 32'h8000_0000,
   parameter int unsigned TILE_STRIDE_POW = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sgi_req_i,
   input  logic [TGT_NUM_POW-1:0] sgi_tgt_bi,
   input  logic [IRQ_NUM_POW-1:0] sgi_code_bi,
   MemSplit32.Master              host,
   output logic                   full_o,
   output logic                   busy_o,
   output logic                   ovf_o,
   output logic                   err_o,
   output sgi_state_e             dbg_state_o
);

   // Same layout as sgi_entry_t, sized by this instance's parameters
   typedef struct packed {
      logic [TGT_NUM_POW-1:0] tgt;
      logic [IRQ_NUM_POW-1:0] code;
   } entry_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("sgi_initiator: TIMEOUT_CYCLES must be at least 1");
   end

   entry_t     push_data;
   entry_t     head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;

   sgi_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ovf_q;

   // Response channel carries nothing for writes
   logic unused_resp;
   assign unused_resp = ^{host.resp, host.rdata};

   assign push_data = '{tgt: sgi_tgt_bi, code: sgi_code_bi};

   sgi_fifo #(
      .WIDTH    (TGT_NUM_POW + IRQ_NUM_POW),
      .DEPTH_POW(FIFO_DEPTH_POW)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (sgi_req_i),
      .data_i (push_data),
      .pop_i  (pop),
      .head_o (head),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

`ifdef SGI_INITIATOR_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_q, err_d;
`endif

   // Issue FSM: load head in IDLE, hold the write in REQ until ack (or timeout)
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pop     = 1'b0;
`ifdef SGI_INITIATOR_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
      err_d    = 1'b0;
`endif
      unique case (state_q)
         SGI_IDLE: begin
            if (!fifo_empty) begin
               req_d   = 1'b1;
               we_d    = 1'b1;
               be_d    = 4'hF;
               addr_d  = sgi_msi_addr(SFR_BASE, 32'(head.tgt), TILE_STRIDE_POW);
               wdata_d = 32'(head.code);
               state_d = SGI_REQ;
`ifdef SGI_INITIATOR_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         SGI_REQ: begin
            if (host.ack) begin
               pop     = 1'b1;
               req_d   = 1'b0;
               state_d = SGI_IDLE;
            end
`ifdef SGI_INITIATOR_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               // Dead target: drop this write so the queue keeps moving
               pop     = 1'b1;
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = SGI_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = SGI_IDLE;
      endcase
   end

   // FSM state, bus output registers and overflow pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SGI_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ovf_q   <= sgi_req_i && fifo_full;
      end
   end

`ifdef SGI_INITIATOR_TIMEOUT_EN
   // Ack-wait counter and timeout pulse
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign host.req   = req_q;
   assign host.we    = we_q;
   assign host.be    = be_q;
   assign host.addr  = addr_q;
   assign host.wdata = wdata_q;

   // The head stays queued until popped, so an empty FIFO outside REQ means idle
   assign full_o      = fifo_full;
   assign busy_o      = !fifo_empty || (state_q == SGI_REQ);
   assign ovf_o       = ovf_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sgi_initiator.sv
// Directed bench for sgi_initiator: a slave model with selectable ack behaviour,
// an in-order write monitor against an expected queue, and a wrap-address instance.
module tb_sgi_initiator;
  import sgi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (default base, 8-cycle timeout when enabled) ----------------
  logic       sgi_req;
  logic [3:0] sgi_tgt;
  logic [3:0] sgi_code;
  logic       full, busy, ovf, err;
  sgi_state_e dbg_state;
  MemSplit32  bus ();

  sgi_initiator #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sgi_req_i  (sgi_req),
    .sgi_tgt_bi (sgi_tgt),
    .sgi_code_bi(sgi_code),
    .host       (bus),
    .full_o     (full),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .err_o      (err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- DUT with a base that wraps ----------------
  logic       w_req;
  logic [3:0] w_tgt;
  logic [3:0] w_code;
  logic       w_full, w_busy, w_ovf, w_err;
  sgi_state_e w_state;
  MemSplit32  bus_w ();

  sgi_initiator #(.SFR_BASE(32'hFFFF_0000)) u_dut_wrap (
    .clk_i      (clk),
    .rst_i      (rst),
    .sgi_req_i  (w_req),
    .sgi_tgt_bi (w_tgt),
    .sgi_code_bi(w_code),
    .host       (bus_w),
    .full_o     (w_full),
    .busy_o     (w_busy),
    .ovf_o      (w_ovf),
    .err_o      (w_err),
    .dbg_state_o(w_state)
  );

  // ---------------- slave models ----------------
  // ack_mode 0: ack = req, 1: ack after req held 3 cycles, 2: never ack
  int   ack_mode;
  int   wait_cnt;
  logic ack_dly;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (bus.req && !bus.ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign ack_dly     = bus.req && (wait_cnt >= 3);
  assign bus.ack     = (ack_mode == 0) ? bus.req : (ack_mode == 1) ? ack_dly : 1'b0;
  assign bus.resp    = 2'b00;
  assign bus.rdata   = 32'h0;
  assign bus_w.ack   = bus_w.req;
  assign bus_w.resp  = 2'b00;
  assign bus_w.rdata = 32'h0;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Write monitor: completed writes in order, field stability while req is high
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [63:0] exp_wr;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req && prev_req) begin
        check_vec("stable_addr", bus.addr, prev_addr);
        check_vec("stable_wdata", bus.wdata, prev_wdata);
      end
      if (bus.req && bus.ack) begin
        check_vec("wr_we", bus.we, 1);
        check_vec("wr_be", bus.be, 4'hF);
        check_vec("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_wr = exp_q.pop_front();
          check_vec("wr_data", {bus.addr, bus.wdata}, exp_wr);
        end
      end
    end
    prev_req   = bus.req;
    prev_addr  = bus.addr;
    prev_wdata = bus.wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_vec({tag, "_busy"}, 64'(busy), 0);
    check_vec({tag, "_left"}, 64'(exp_q.size()), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_vec({tag, "_req"}, bus.req, 0);
    check_vec({tag, "_we"}, bus.we, 0);
    check_vec({tag, "_addr"}, bus.addr, 0);
    check_vec({tag, "_wdata"}, bus.wdata, 0);
    check_vec({tag, "_be"}, bus.be, 0);
    check_vec({tag, "_full"}, full, 0);
    check_vec({tag, "_busy"}, busy, 0);
    check_vec({tag, "_ovf"}, ovf, 0);
    check_vec({tag, "_err"}, err, 0);
    check_vec({tag, "_state"}, dbg_state, SGI_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    sgi_req = 1'b0; sgi_tgt = 4'h0; sgi_code = 4'h0;
    w_req = 1'b0; w_tgt = 4'h0; w_code = 4'h0;
    ack_mode = 0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_rst");

    // Single SGI, combinational ack
    exp_q.push_back({32'h8003_000C, 32'h5});
    sgi_req = 1'b1; sgi_tgt = 4'd3; sgi_code = 4'd5;
    @(negedge clk);
    sgi_req = 1'b0;
    check_vec("t1_req_lat", bus.req, 0);
    check_vec("t1_busy", busy, 1);
    @(negedge clk);
    check_vec("t1_req", bus.req, 1);
    check_vec("t1_addr", bus.addr, 32'h8003_000C);
    check_vec("t1_wdata", bus.wdata, 32'h5);
    @(negedge clk);
    check_vec("t1_req_low", bus.req, 0);
    check_vec("t1_busy_low", busy, 0);
    wait_drain("t1");

    // Two back-to-back strobes, combinational ack: req 1,0,1,0
    exp_q.push_back({32'h800F_000C, 32'h6});
    exp_q.push_back({32'h800F_000C, 32'h7});
    sgi_req = 1'b1; sgi_tgt = 4'd15; sgi_code = 4'd6;
    @(negedge clk);
    sgi_code = 4'd7;
    @(negedge clk);
    sgi_req = 1'b0;
    check_vec("tp_req_a", bus.req, 1);
    @(negedge clk);
    check_vec("tp_gap", bus.req, 0);
    @(negedge clk);
    check_vec("tp_req_b", bus.req, 1);
    check_vec("tp_wdata_b", bus.wdata, 32'h7);
    @(negedge clk);
    check_vec("tp_end", bus.req, 0);
    wait_drain("tp");

    // Four back-to-back strobes, 3-cycle ack; fifth strobe lands on the pop edge
    ack_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({32'h8000_000C, 32'(i)});
      sgi_req = 1'b1; sgi_tgt = 4'd0; sgi_code = 4'(i);
      @(negedge clk);
    end
    sgi_req = 1'b0;
    check_vec("t2_full", full, 1);
    @(negedge clk);
    check_vec("t2_full_hold", full, 1);
    check_vec("t2_ovf_none", ovf, 0);
    sgi_req = 1'b1; sgi_code = 4'd5;
    @(negedge clk);
    sgi_req = 1'b0;
    check_vec("t3_ovf", ovf, 1);
    check_vec("t3_full_after_pop", full, 0);
    @(negedge clk);
    check_vec("t3_ovf_pulse", ovf, 0);
    wait_drain("t2");

`ifdef SGI_INITIATOR_TIMEOUT_EN
    // Timeout: first write never acked, second one acked normally
    begin
      int n;
      ack_mode = 2;
      exp_q.push_back({32'h8001_000C, 32'hB});
      sgi_req = 1'b1; sgi_tgt = 4'd1; sgi_code = 4'hA;
      @(negedge clk);
      sgi_code = 4'hB;
      @(negedge clk);
      sgi_req = 1'b0;
      check_vec("to_req", bus.req, 1);
      check_vec("to_wdata_a", bus.wdata, 32'hA);
      n = 0;
      while (!err && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_vec("to_cycles", 64'(n), 8);
      check_vec("to_req_drop", bus.req, 0);
      ack_mode = 0;
      @(negedge clk);
      check_vec("to_err_pulse", err, 0);
      check_vec("to_req_b", bus.req, 1);
      check_vec("to_wdata_b", bus.wdata, 32'hB);
      wait_drain("to");
    end
`endif

    // Async reset mid-REQ with a slave that never acks
    ack_mode = 2;
    sgi_req = 1'b1; sgi_tgt = 4'd5; sgi_code = 4'd7;
    @(negedge clk);
    sgi_req = 1'b0;
    @(negedge clk);
    check_vec("ar_req", bus.req, 1);
`ifdef SGI_INITIATOR_TIMEOUT_EN
    repeat (4) @(negedge clk);
`else
    repeat (20) @(negedge clk);
`endif
    check_vec("ar_still_req", bus.req, 1);
    check_vec("ar_no_err", err, 0);
    #2 rst = 1'b1;
    #1;
    check_vec("ar_req_async", bus.req, 0);
    check_vec("ar_busy", busy, 0);
    check_vec("ar_state", dbg_state, SGI_IDLE);
    @(negedge clk);
    check_reset_state("ar_hold");
    rst = 1'b0;
    ack_mode = 0;
    exp_q.push_back({32'h8002_000C, 32'h9});
    sgi_req = 1'b1; sgi_tgt = 4'd2; sgi_code = 4'd9;
    @(negedge clk);
    sgi_req = 1'b0;
    @(negedge clk);
    check_vec("ar_fresh_req", bus.req, 1);
    check_vec("ar_fresh_addr", bus.addr, 32'h8002_000C);
    wait_drain("ar");

    // Address wrap on the second instance
    w_req = 1'b1; w_tgt = 4'd1; w_code = 4'd3;
    @(negedge clk);
    w_req = 1'b0;
    @(negedge clk);
    check_vec("wrap_req", bus_w.req, 1);
    check_vec("wrap_addr", bus_w.addr, 32'h0000_000C);
    check_vec("wrap_wdata", bus_w.wdata, 32'h3);
    @(negedge clk);
    check_vec("wrap_req_low", bus_w.req, 0);
    check_vec("wrap_busy", w_busy, 0);
    check_vec("wrap_err", w_err, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
